// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage registers.
package pipe_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 112;
endpackage

// File: rtl/pipe_entry.sv
// One held beat: control + datapath register with load enable and a
// synchronous control clear that leaves the datapath untouched.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clear wins over load so a beat offered during a kill never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_clr) begin
      r_ctrl <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;
endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic stage register between two pipeline stages with ready/valid flow
// control, optional two-entry skid buffer and a bubble-inserting flush.
//
// Handshake: a beat moves on a cycle edge only when valid and ready are both
// high at that edge; valid never waits on ready, and once out_valid is high
// the head beat stays stable until it is released.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [1:0]        dbg_state
);
  logic              w_accept;
  logic              w_release;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;

  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;
  assign out_ctrl  = out_valid ? w_main_ctrl : '0;
  assign out_data  = w_main_data;

  generate
    if (SKID != 0) begin : g_skid
      stage_state_t      r_state;
      stage_state_t      w_next;
      logic              r_in_ready;
      logic              w_main_load;
      logic              w_skid_load;
      logic              w_main_from_skid;
      logic [CTRL_W-1:0] w_skid_ctrl;
      logic [DATA_W-1:0] w_skid_data;
      logic [CTRL_W-1:0] w_main_in_ctrl;
      logic [DATA_W-1:0] w_main_in_data;

      always_comb begin
        w_next           = r_state;
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
          w_next = ST_EMPTY;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_accept) begin
                w_next      = ST_ONE;
                w_main_load = 1'b1;
              end
            end
            ST_ONE: begin
              if (w_accept && w_release) begin
                w_main_load = 1'b1;
              end else if (w_accept) begin
                w_next      = ST_TWO;
                w_skid_load = 1'b1;
              end else if (w_release) begin
                w_next = ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (w_release) begin
                w_next           = ST_ONE;
                w_main_load      = 1'b1;
                w_main_from_skid = 1'b1;
              end
            end
            default: w_next = ST_EMPTY;
          endcase
        end
      end

      // in_ready is registered from the next state, so out_ready never
      // reaches in_ready combinationally.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b1;
        end else begin
          r_state    <= w_next;
          r_in_ready <= (w_next != ST_TWO);
        end
      end

      assign w_main_in_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;
      assign w_main_in_data = w_main_from_skid ? w_skid_data : in_data;

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_main_load),
        .i_clr  (flush),
        .i_ctrl (w_main_in_ctrl),
        .i_data (w_main_in_data),
        .o_ctrl (w_main_ctrl),
        .o_data (w_main_data)
      );

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_skid_load),
        .i_clr  (flush),
        .i_ctrl (in_ctrl),
        .i_data (in_data),
        .o_ctrl (w_skid_ctrl),
        .o_data (w_skid_data)
      );

      assign in_ready  = r_in_ready;
      assign out_valid = (r_state != ST_EMPTY);
      assign occ       = r_state;
      assign dbg_state = r_state;
    end else begin : g_single
      logic r_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_accept) begin
          r_valid <= 1'b1;
        end else if (w_release) begin
          r_valid <= 1'b0;
        end
      end

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_clr  (flush),
        .i_ctrl (in_ctrl),
        .i_data (in_data),
        .o_ctrl (w_main_ctrl),
        .o_data (w_main_data)
      );

      assign in_ready  = !r_valid | out_ready;
      assign out_valid = r_valid;
      assign occ       = {1'b0, r_valid};
      assign dbg_state = r_valid ? ST_ONE : ST_EMPTY;
    end
  endgenerate
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: skid variant (dut) and single-entry
// variant (dut0) driven side by side from one sequence of scenario tasks.
module tb_pipe_stage_elastic;
  localparam int CW = 8;
  localparam int DW = 112;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occ, dbg_state;

  logic          s0_flush, s0_in_valid, s0_out_ready;
  logic [CW-1:0] s0_in_ctrl;
  logic [DW-1:0] s0_in_data;
  logic          s0_in_ready, s0_out_valid;
  logic [CW-1:0] s0_out_ctrl;
  logic [DW-1:0] s0_out_data;
  logic [1:0]    s0_occ, s0_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occ(occ), .dbg_state(dbg_state)
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_ctrl(s0_in_ctrl), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_ctrl(s0_out_ctrl),
    .out_data(s0_out_data), .occ(s0_occ), .dbg_state(s0_dbg_state)
  );

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0;
    s0_in_ctrl = '0; s0_in_data = '0;
    #1;
    n_checks++;
    if ({out_valid, occ, in_ready, dbg_state, out_ctrl} !== {1'b0, 2'd0, 1'b1, 2'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_flags: got %h expected %h",
               {out_valid, occ, in_ready, dbg_state, out_ctrl}, {1'b0, 2'd0, 1'b1, 2'd0, 8'h00});
    end
    n_checks++;
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data);
    end
    n_checks++;
    if ({s0_in_ready, s0_out_valid, s0_occ} !== {1'b1, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL reset_skid0: got %b expected 1000", {s0_in_ready, s0_out_valid, s0_occ});
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({in_ready, occ} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL reset_release: got %b expected 100", {in_ready, occ});
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(8'h10 + 8'(i), DW'(i));
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_in_ready beat %0d: got %b expected 1", i, in_ready);
      end
      tick();
      n_checks++;
      if ({out_valid, occ, in_ready} !== {1'b1, 2'd1, 1'b1}) begin
        n_fail++; $display("FAIL stream_flags beat %0d: got %b expected 1011", i, {out_valid, occ, in_ready});
      end
      n_checks++;
      if (out_data !== DW'(i) || out_ctrl !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("FAIL stream_beat %0d: got data %h ctrl %h expected data %h ctrl %h",
                 i, out_data, out_ctrl, DW'(i), 8'h10 + 8'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, occ, out_ctrl} !== {1'b0, 2'd0, 8'h00}) begin
      n_fail++; $display("FAIL stream_drain: got %h expected 0", {out_valid, occ, out_ctrl});
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    send(8'hA1, 112'hA);
    tick();
    send(8'hB1, 112'hB);
    tick();
    n_checks++;
    if ({occ, in_ready, out_valid} !== {2'd2, 1'b0, 1'b1} || out_data !== 112'hA || out_ctrl !== 8'hA1) begin
      n_fail++;
      $display("FAIL bp_full: got occ %0d in_ready %b data %h ctrl %h expected occ 2 in_ready 0 data a ctrl a1",
               occ, in_ready, out_data, out_ctrl);
    end
    send(8'hC1, 112'hC);
    tick();
    n_checks++;
    if (occ !== 2'd2 || out_data !== 112'hA || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold_off: got occ %0d data %h in_ready %b expected occ 2 data a in_ready 0",
                         occ, out_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (occ !== 2'd1 || out_data !== 112'hB || out_ctrl !== 8'hB1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: got occ %0d data %h ctrl %h in_ready %b expected occ 1 data b ctrl b1 in_ready 1",
                         occ, out_data, out_ctrl, in_ready);
    end
    tick();
    n_checks++;
    if (occ !== 2'd1 || out_data !== 112'hC || out_ctrl !== 8'hC1) begin
      n_fail++; $display("FAIL bp_third: got occ %0d data %h ctrl %h expected occ 1 data c ctrl c1",
                         occ, out_data, out_ctrl);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, occ} !== {1'b0, 2'd0}) begin
      n_fail++; $display("FAIL bp_drain: got %b expected 000", {out_valid, occ});
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(8'h5A, 112'h11);
    tick();
    send(8'h5A, 112'h22);
    tick();
    n_checks++;
    if (occ !== 2'd2 || out_ctrl !== 8'h5A) begin
      n_fail++; $display("FAIL flush_setup: got occ %0d ctrl %h expected occ 2 ctrl 5a", occ, out_ctrl);
    end
    flush = 1'b1;
    send(8'h3C, 112'hD);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, occ, in_ready, out_ctrl} !== {1'b0, 2'd0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL flush_result: got %h expected %h",
                         {out_valid, occ, in_ready, out_ctrl}, {1'b0, 2'd0, 1'b1, 8'h00});
    end
    n_checks++;
    if (out_data !== 112'h11) begin
      n_fail++; $display("FAIL flush_data_kept: got %h expected 11", out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_no_emerge cycle %0d: got out_valid %b data %h expected 0", i, out_valid, out_data);
      end
    end
    send(8'h4E, 112'hE);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (occ !== 2'd1 || out_data !== 112'hE || out_ctrl !== 8'h4E) begin
      n_fail++; $display("FAIL flush_resume: got occ %0d data %h ctrl %h expected occ 1 data e ctrl 4e",
                         occ, out_data, out_ctrl);
    end
    tick();
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    send(8'h21, 112'h21);
    tick();
    send(8'h22, 112'h22);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 8'h22) begin
      n_fail++; $display("FAIL bubble_before: got valid %b ctrl %h expected valid 1 ctrl 22", out_valid, out_ctrl);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
        n_fail++; $display("FAIL bubble_gap cycle %0d: got valid %b ctrl %h expected valid 0 ctrl 00",
                           i, out_valid, out_ctrl);
      end
    end
    send(8'h23, 112'h23);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 112'h23 || out_ctrl !== 8'h23) begin
      n_fail++; $display("FAIL bubble_after: got valid %b data %h ctrl %h expected valid 1 data 23 ctrl 23",
                         out_valid, out_data, out_ctrl);
    end
    tick();
  endtask

  task automatic test_skid0();
    logic [11:0]   pat;
    logic          m_valid;
    logic          exp_rdy;
    logic          rel;
    logic [DW-1:0] next_d;
    logic [DW-1:0] exp_d;
    pat     = 12'b1011_0011_0101;
    m_valid = 1'b0;
    next_d  = 112'h100;
    exp_q.delete();
    for (int k = 0; k < 12; k++) begin
      s0_in_valid  = 1'b1;
      s0_in_data   = next_d;
      s0_in_ctrl   = next_d[7:0];
      s0_out_ready = pat[k];
      #1;
      exp_rdy = !m_valid | pat[k];
      rel     = m_valid & pat[k];
      n_checks++;
      if (s0_in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL skid0_in_ready cycle %0d: got %b expected %b", k, s0_in_ready, exp_rdy);
      end
      if (rel) begin
        exp_d = exp_q.pop_front();
        n_checks++;
        if (s0_out_data !== exp_d) begin
          n_fail++; $display("FAIL skid0_order cycle %0d: got %h expected %h", k, s0_out_data, exp_d);
        end
      end
      tick();
      if (exp_rdy) begin
        m_valid = 1'b1;
        exp_q.push_back(next_d);
        next_d = next_d + 1;
      end else if (rel) begin
        m_valid = 1'b0;
      end
      n_checks++;
      if (s0_out_valid !== m_valid || s0_out_ctrl !== (m_valid ? exp_q[0][7:0] : 8'h00)) begin
        n_fail++; $display("FAIL skid0_out cycle %0d: got valid %b ctrl %h expected valid %b",
                           k, s0_out_valid, s0_out_ctrl, m_valid);
      end
    end
    s0_in_valid  = 1'b0;
    s0_out_ready = 1'b1;
    #1;
    if (m_valid) begin
      exp_d = exp_q.pop_front();
      n_checks++;
      if (s0_out_data !== exp_d) begin
        n_fail++; $display("FAIL skid0_last: got %h expected %h", s0_out_data, exp_d);
      end
    end
    tick();
    n_checks++;
    if (s0_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL skid0_drain: got %b expected 0", s0_out_valid);
    end
    s0_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(8'h61, 112'h61);
    s0_in_valid = 1'b1;
    s0_in_ctrl  = 8'h71;
    s0_in_data  = 112'h71;
    tick();
    s0_in_valid = 1'b0;
    send(8'h62, 112'h62);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (occ !== 2'd2 || s0_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_setup: got occ %0d s0_valid %b expected occ 2 s0_valid 1", occ, s0_out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, occ, out_ctrl, s0_out_valid, s0_occ} !== {1'b0, 2'd0, 8'h00, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL rstmid_immediate: got %h expected 0",
                         {out_valid, occ, out_ctrl, s0_out_valid, s0_occ});
    end
    n_checks++;
    if (out_data !== '0) begin
      n_fail++; $display("FAIL rstmid_data: got %h expected 0", out_data);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({in_ready, occ, out_valid} !== {1'b1, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL rstmid_after: got %b expected 1000", {in_ready, occ, out_valid});
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_bubble();
    test_skid0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline stage register, the next generation of our fixed ID/EX-style latches. It carries a control field and a datapath field between two pipeline stages and adds ready/valid flow control, an optional two-entry skid buffer, and a synchronous flush that inserts bubbles. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB, so back-pressure from a stalled later stage propagates without combinational ready chains.

## Interface
- CTRL_W, default 8: control-field width (mem_to_reg, mem_write, alu_src, alu_control…); zeroed on flush/bubble.
- DATA_W, default 112: datapath-field width (pc, RD1, RD2, imm…); not cleared on flush.
- SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream datapath field.
- out_valid  out  1  held beat presented downstream.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control of head entry; 0 when out_valid=0.
- out_data  out  DATA_W  datapath of head entry.
- occ  out  2  entries held (0..2; max 1 when SKID=0).

## Operation
- Accept = in_valid & in_ready; release = out_valid & out_ready.
- SKID=1 states: ST_EMPTY (occ 0), ST_ONE (main full), ST_TWO (main + skid full).
  - EMPTY: accept → ONE.
  - ONE: accept & !release → TWO (beat into skid); release & !accept → EMPTY; both → ONE (main reloaded).
  - TWO: release → ONE (skid moves to main); accept impossible (in_ready=0).
- in_ready (SKID=1) is a flop: 1 unless next state is TWO.
- SKID=0: single entry; in_ready = !out_valid | out_ready (combinational); accept & release in the same cycle replaces the entry.
- Ordering strictly FIFO; no beat duplicated or dropped except by flush.
- flush: highest priority after rst. Next cycle: occ=0, out_valid=0, out_ctrl=0, both entries' ctrl cleared, data registers retain old values, in_ready=1. A beat offered in the flush cycle is dropped even if in_ready=1. Release in the flush cycle still counts downstream.
- out_ctrl is forced to 0 whenever out_valid=0 (bubble = NOP control).

## Timing
- Reset values: out_valid 0, out_ctrl 0, out_data 0, occ 0, in_ready 1 (SKID=1); SKID=0 in_ready follows its equation (1).
- Latency: accepted beat appears on out_* the next cycle when EMPTY; throughput 1 beat/cycle with out_ready held 1.
- SKID=1: in_ready depends only on flops; no path out_ready → in_ready.
- rst mid-operation: all entries lost immediately; no partial state survives deassertion.
- flush and rst together: rst wins (identical result).
- Inputs in_ctrl/in_data sampled only on accept; values outside accept are don't-care.

## Structure
- Shared package pipe_pkg: typedef enum logic [1:0] stage_state_t {ST_EMPTY, ST_ONE, ST_TWO}; default widths CTRL_W_DEF=8, DATA_W_DEF=112.
- One natural sub-module: pipe_entry (CTRL_W+DATA_W register with load enable and synchronous ctrl clear), instantiated twice for main and skid (once when SKID=0).
- SKID selected by generate; both variants in the same file.

## Test plan
- Reset: assert rst mid-traffic with occ=2 → same cycle out_valid=0, out_ctrl=0, occ=0; after release in_ready=1.
- Streaming: SKID=1, out_ready=1, beats data 0x1..0x8 one per cycle → out_data 0x1..0x8 one cycle later, in_ready stays 1, occ=1.
- Back-pressure: out_ready=0, send 0xA then 0xB → occ=2, in_ready=0 the cycle after 0xB; 0xC held off; raise out_ready → 0xA, 0xB, 0xC in order.
- Flush: occ=2 with ctrl 0x5A, flush=1 while in_valid with 0xD → next cycle occ=0, out_ctrl=0x00, in_ready=1, 0xD never emerges.
- SKID=0: out_ready toggling 1/0 with continuous in_valid → in_ready equals !out_valid|out_ready each cycle, no loss, order preserved.
- Bubble: in_valid=0 for 3 cycles in a stream → out_valid=0 and out_ctrl=0 for exactly 3 cycles.
